// File: rtl/rr_var_picker.sv
// rr_var_picker: round-robin pick of the first set mask bit at or after an
// internal start pointer, wrapping modulo N. ptr advances past each real pick.
// Latency: 3 cycles from request handshake to pick_valid; one request in flight.
// Backpressure: the result holds in HOLD until pick_ready; req_ready stays low
// until the result handshake.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready, mask   request handshake and N-bit candidate mask
//   pick_valid/pick_ready       result handshake
//   pick_idx, pick_none         chosen absolute index / no candidate set

// Rotates din by amt positions (amt < N). DIR=1 rotates right, so bit 0 of
// dout is din[amt]; DIR=0 rotates left. Works for any N, power of two or not.
module rr_var_picker_rotator #(
  parameter int N   = 8,
  parameter int W   = 3,
  parameter int DIR = 1
) (
  input  logic [N-1:0] din,
  input  logic [W-1:0] amt,
  output logic [N-1:0] dout
);
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;

  always_comb begin
    dbl = {din, din};
    if (DIR == 1) begin
      shifted = dbl >> amt;
      dout    = shifted[N-1:0];
    end else begin
      shifted = dbl << amt;
      dout    = shifted[2*N-1:N];
    end
  end
endmodule

module rr_var_picker #(
  parameter int N = 8,
  localparam int W = $clog2(N)  // ceil(log2 N): index width
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] mask,
  output logic         pick_valid,
  input  logic         pick_ready,
  output logic [W-1:0] pick_idx,
  output logic         pick_none
);
  typedef enum logic [1:0] {IDLE, ROT, ENC, HOLD} state_t;

  localparam logic [W:0]   N_EXT = (W+1)'(N);
  localparam logic [W-1:0] LAST  = W'(N-1);

  state_t         state, state_nxt;
  logic [W-1:0]   ptr;
  logic [N-1:0]   rot_q;
  logic [W-1:0]   pos_q;
  logic           any_q;

  logic [N-1:0]   rot_out;
  logic [W-1:0]   pos;
  logic           any;
  logic [W:0]     idx_sum;
  logic [W-1:0]   idx;

  rr_var_picker_rotator #(.N(N), .W(W), .DIR(1)) u_rot (
    .din  (mask),
    .amt  (ptr),
    .dout (rot_out)
  );

  // Lowest set bit of the aligned mask: scanning high to low, the last hit wins.
  always_comb begin
    pos = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_q[i]) begin
        pos = W'(i);
        any = 1'b1;
      end
    end
  end

  // Map the rotated position back to an absolute index; ptr+pos < 2N so one
  // conditional subtract is enough.
  always_comb begin
    idx_sum = {1'b0, ptr} + {1'b0, pos_q};
    idx     = (idx_sum >= N_EXT) ? W'(idx_sum - N_EXT) : W'(idx_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ROT;
      end
      ROT:  state_nxt = ENC;
      ENC:  state_nxt = HOLD;
      HOLD: if (pick_valid && pick_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      rot_q      <= '0;
      pos_q      <= '0;
      any_q      <= 1'b0;
      pick_valid <= 1'b0;
      pick_idx   <= '0;
      pick_none  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) rot_q <= rot_out;
        ROT: begin
          pos_q <= pos;
          any_q <= any;
        end
        ENC: begin
          pick_idx  <= any_q ? idx : '0;
          pick_none <= !any_q;
        end
        HOLD: begin
          // First HOLD cycle publishes the result registered in ENC; this
          // gives the fixed three-cycle request-to-result latency.
          if (!pick_valid) begin
            pick_valid <= 1'b1;
          end else if (pick_ready) begin
            pick_valid <= 1'b0;
            if (!pick_none) ptr <= (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_var_picker.sv
`timescale 1ns/1ps
module tb_rr_var_picker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rv8, rr8, pv8, pr8, pn8;
  logic [7:0] m8;
  logic [2:0] pi8;
  logic       rv6, rr6, pv6, pr6, pn6;
  logic [5:0] m6;
  logic [2:0] pi6;

  rr_var_picker #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .req_valid(rv8), .req_ready(rr8), .mask(m8),
    .pick_valid(pv8), .pick_ready(pr8), .pick_idx(pi8), .pick_none(pn8)
  );
  rr_var_picker #(.N(6)) dut6 (
    .clk(clk), .rst(rst), .req_valid(rv6), .req_ready(rr6), .mask(m6),
    .pick_valid(pv6), .pick_ready(pr6), .pick_idx(pi6), .pick_none(pn6)
  );

  int total = 0;
  int passed = 0;
  bit sel6 = 1'b0;
  bit hold_ready = 1'b0;

  int cur_rr, cur_pv, cur_pi, cur_pn;
  always_comb begin
    cur_rr = int'(sel6 ? rr6 : rr8);
    cur_pv = int'(sel6 ? pv6 : pv8);
    cur_pi = int'(sel6 ? pi6 : pi8);
    cur_pn = int'(sel6 ? pn6 : pn8);
  end

  typedef struct {int idx; int none;} exp_t;
  exp_t sb[$];

  typedef struct {logic [7:0] mask; int idx; int none;} vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit v, input logic [7:0] m, input bit r);
    if (sel6) begin
      rv6 = v; m6 = m[5:0]; pr6 = r;
    end else begin
      rv8 = v; m8 = m; pr8 = r;
    end
  endtask

  // Wait (bounded) for pick_valid; returns negedges counted since the first
  // negedge after the request handshake.
  task automatic wait_valid(output int k);
    k = 0;
    while (cur_pv == 0 && k < 12) begin
      @(negedge clk);
      k++;
    end
  endtask

  // One full request/result transaction; called at a negedge.
  task automatic send(input string name, input logic [7:0] m, input int eidx, input int enone);
    int k;
    exp_t e;
    k = 0;
    while (cur_rr == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "/req_ready"}, cur_rr, 1);
    drive(1'b1, m, hold_ready);
    sb.push_back('{eidx, enone});
    @(negedge clk);
    drive(1'b0, 8'h00, hold_ready);
    wait_valid(k);
    check({name, "/latency"}, k, 3);
    e = sb.pop_front();
    check({name, "/pick_idx"}, cur_pi, e.idx);
    check({name, "/pick_none"}, cur_pn, e.none);
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, hold_ready);
    check({name, "/valid_clr"}, cur_pv, 0);
    check({name, "/ready_back"}, cur_rr, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rv8 = 0; m8 = '0; pr8 = 0;
    rv6 = 0; m6 = '0; pr6 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    exp_t e;
    tbl[0] = '{8'h04, 2, 0};
    tbl[1] = '{8'h05, 0, 0};
    tbl[2] = '{8'h00, 0, 1};
    tbl[3] = '{8'hFF, 1, 0};
    tbl[4] = '{8'h80, 7, 0};
    tbl[5] = '{8'h81, 0, 0};
    tbl[6] = '{8'h10, 4, 0};
    tbl[7] = '{8'h10, 4, 0};
    tbl[8] = '{8'h60, 5, 0};
    tbl[9] = '{8'h01, 0, 0};

    // Reset values, checked while rst is still high
    rst = 1'b1;
    rv8 = 0; m8 = '0; pr8 = 0;
    rv6 = 0; m6 = '0; pr6 = 0;
    repeat (2) @(negedge clk);
    check("rst/pick_valid", cur_pv, 0);
    check("rst/pick_idx", cur_pi, 0);
    check("rst/pick_none", cur_pn, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst/req_ready", cur_rr, 1);

    // Table of single picks, pointer carried across rows
    for (int i = 0; i < 10; i++)
      send($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].idx, tbl[i].none);

    // All candidates set, pick_ready tied high: walk 0..7 then wrap to 0
    do_reset();
    hold_ready = 1'b1;
    for (int i = 0; i < 9; i++)
      send($sformatf("ff%0d", i), 8'hFF, i % 8, 0);
    hold_ready = 1'b0;

    // Backpressure in HOLD with req_valid high and a changing mask
    do_reset();
    drive(1'b1, 8'h08, 1'b0);
    sb.push_back('{3, 0});
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    wait_valid(k);
    check("bp/latency", k, 3);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      @(negedge clk);
      check($sformatf("bp%0d/pick_valid", i), cur_pv, 1);
      check($sformatf("bp%0d/pick_idx", i), cur_pi, e.idx);
      check($sformatf("bp%0d/pick_none", i), cur_pn, e.none);
      check($sformatf("bp%0d/req_ready", i), cur_rr, 0);
    end
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    check("bp/valid_clr", cur_pv, 0);
    check("bp/ready_back", cur_rr, 1);
    repeat (4) @(negedge clk);
    check("bp/no_extra", cur_pv, 0);
    send("bp_after", 8'h11, 4, 0);  // ptr moved to 4 only on the handshake

    // Reset asserted for one cycle while the request sits in ENC
    drive(1'b1, 8'h04, 1'b0);
    sb.push_back('{2, 0});
    @(negedge clk);                 // ROT
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);                 // ENC
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();                    // request discarded by reset
    check("rst_enc/pick_idx", cur_pi, 0);
    check("rst_enc/req_ready", cur_rr, 1);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cur_pv != 0) k++;
    end
    check("rst_enc/no_valid", k, 0);
    send("rst_enc_next", 8'h81, 0, 0);

    // N=6 instance: wrap at a non-power-of-two size
    sel6 = 1'b1;
    do_reset();
    send("n6_a", 8'h10, 4, 0);      // ptr -> 5
    send("n6_b", 8'h01, 0, 0);      // wraps from 5 to 0, ptr -> 1
    send("n6_c", 8'h10, 4, 0);      // ptr -> 5
    send("n6_d", 8'h20, 5, 0);      // ptr wraps to 0
    send("n6_e", 8'h01, 0, 0);      // ptr -> 1
    send("n6_f", 8'h3F, 1, 0);
    send("n6_g", 8'h00, 0, 1);
    sel6 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
